// File: rtl/branch_predict_unit.sv
// Branch/next-PC unit with a direct-mapped BTB (2-bit counters), EX-stage
// resolution with a registered redirect on mispredict, and performance counters.
module branch_predict_unit #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  output logic [31:0]      f_pred_npc,
  input  logic             r_valid,
  input  logic [31:0]      r_pc,
  input  logic [3:0]       r_cb,
  input  logic [25:0]      r_instr_index,
  input  logic [15:0]      r_offset,
  input  logic [31:0]      r_rs,
  input  logic [31:0]      r_rt,
  input  logic             r_pred_taken,
  input  logic [31:0]      r_pred_npc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];

  logic             redirect_valid_r;
  logic [31:0]      redirect_pc_r;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] mis_cnt_r;

  logic [IDX_W-1:0] f_idx_s, r_idx_s;
  logic             f_hit_s, r_hit_s;
  logic [31:0]      seq_s, btarget_s, jtarget_s, actual_npc_s;
  logic             taken_s, is_j_s, is_cond_s, mispredict_s, accept_s;
  logic             upd_en_s, upd_valid_s;
  logic [31:0]      upd_target_s;
  logic [1:0]       upd_ctr_s;
  logic             pred_taken_unused_s;

  // Training uses the resolved outcome, not the carried prediction bit.
  assign pred_taken_unused_s = ^{r_pred_taken, r_pc[1:0], f_pc[1:0]};

  // Fetch-side lookup: zero latency, reads the pre-update table contents.
  always_comb begin
    f_idx_s      = f_pc[IDX_W+1:2];
    f_hit_s      = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_pc[31:IDX_W+2]);
    f_pred_taken = f_hit_s && ctr_r[f_idx_s][1];
    if (f_pred_taken) begin
      f_pred_npc = target_r[f_idx_s];
    end else begin
      f_pred_npc = f_pc + 32'd4;
    end
  end

  // Resolve the actual outcome and detect mispredict against the carried PC.
  always_comb begin
    r_idx_s   = r_pc[IDX_W+1:2];
    r_hit_s   = valid_r[r_idx_s] && (tag_r[r_idx_s] == r_pc[31:IDX_W+2]);
    seq_s     = r_pc + 32'd4;
    btarget_s = seq_s + {{14{r_offset[15]}}, r_offset, 2'b00};
    jtarget_s = {r_pc[31:28], r_instr_index, 2'b00};
    is_j_s    = (r_cb == 4'd1);
    is_cond_s = (r_cb >= 4'd2) && (r_cb <= 4'd7);
    case (r_cb)
      4'd1:    taken_s = 1'b1;
      4'd2:    taken_s = (r_rs == r_rt);
      4'd3:    taken_s = (r_rs != r_rt);
      4'd4:    taken_s = ($signed(r_rs) <= 32'sd0);
      4'd5:    taken_s = ($signed(r_rs) >  32'sd0);
      4'd6:    taken_s = ($signed(r_rs) <  32'sd0);
      4'd7:    taken_s = ($signed(r_rs) >= 32'sd0);
      default: taken_s = 1'b0;
    endcase
    if (taken_s) begin
      actual_npc_s = is_j_s ? jtarget_s : btarget_s;
    end else begin
      actual_npc_s = seq_s;
    end
    mispredict_s = (r_pred_npc != actual_npc_s);
    accept_s     = r_valid && !redirect_valid_r;
  end

  // Next value of the resolving entry; a hit with no branch class means aliasing.
  always_comb begin
    upd_en_s     = 1'b0;
    upd_valid_s  = 1'b1;
    upd_target_s = target_r[r_idx_s];
    upd_ctr_s    = ctr_r[r_idx_s];
    if (accept_s) begin
      if (r_hit_s) begin
        upd_en_s = 1'b1;
        if (is_j_s) begin
          upd_ctr_s    = 2'd3;
          upd_target_s = jtarget_s;
        end else if (is_cond_s) begin
          if (taken_s) begin
            upd_ctr_s    = (ctr_r[r_idx_s] == 2'd3) ? 2'd3 : ctr_r[r_idx_s] + 2'd1;
            upd_target_s = btarget_s;
          end else begin
            upd_ctr_s    = (ctr_r[r_idx_s] == 2'd0) ? 2'd0 : ctr_r[r_idx_s] - 2'd1;
          end
        end else begin
          upd_valid_s = 1'b0;
        end
      end else if (taken_s) begin
        upd_en_s     = 1'b1;
        upd_target_s = is_j_s ? jtarget_s : btarget_s;
        upd_ctr_s    = is_j_s ? 2'd3 : 2'd2;
      end else begin
        upd_en_s = 1'b0;
      end
    end else begin
      upd_en_s = 1'b0;
    end
  end

  // BTB storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'd0;
      end
    end else if (upd_en_s) begin
      valid_r[r_idx_s]  <= upd_valid_s;
      tag_r[r_idx_s]    <= r_pc[31:IDX_W+2];
      target_r[r_idx_s] <= upd_target_s;
      ctr_r[r_idx_s]    <= upd_ctr_s;
    end
  end

  // Redirect pulse and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
      br_cnt_r         <= {CNT_W{1'b0}};
      mis_cnt_r        <= {CNT_W{1'b0}};
    end else begin
      redirect_valid_r <= accept_s && mispredict_s;
      if (accept_s && mispredict_s) begin
        redirect_pc_r <= actual_npc_s;
      end
      if (accept_s && (is_j_s || is_cond_s) && (br_cnt_r != {CNT_W{1'b1}})) begin
        br_cnt_r <= br_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s && mispredict_s && (mis_cnt_r != {CNT_W{1'b1}})) begin
        mis_cnt_r <= mis_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign br_cnt         = br_cnt_r;
  assign mis_cnt        = mis_cnt_r;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: scoreboarded redirects, BTB
// lookups, counter saturation (second instance with CNT_W = 2) and async reset.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] f_pc = 32'd0;
  logic        r_valid = 1'b0;
  logic [31:0] r_pc = 32'd0;
  logic [3:0]  r_cb = 4'd0;
  logic [25:0] r_instr_index = 26'd0;
  logic [15:0] r_offset = 16'd0;
  logic [31:0] r_rs = 32'd0, r_rt = 32'd0;
  logic        r_pred_taken = 1'b0;
  logic [31:0] r_pred_npc = 32'd0;

  logic        f_pred_taken, s_f_pred_taken;
  logic [31:0] f_pred_npc, s_f_pred_npc;
  logic        redirect_valid, s_redirect_valid;
  logic [31:0] redirect_pc, s_redirect_pc;
  logic [15:0] br_cnt, mis_cnt;
  logic [1:0]  s_br_cnt, s_mis_cnt;

  typedef struct packed { logic v; logic [31:0] pc; } exp_t;
  exp_t sb_q[$];

  int tests = 0, fails = 0;
  int exp_br = 0, exp_mis = 0;
  logic [31:0] last_rpc = 32'd0;

  always #5 clk = ~clk;

  branch_predict_unit #(.IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_npc(f_pred_npc),
    .r_valid(r_valid), .r_pc(r_pc), .r_cb(r_cb), .r_instr_index(r_instr_index), .r_offset(r_offset),
    .r_rs(r_rs), .r_rt(r_rt), .r_pred_taken(r_pred_taken), .r_pred_npc(r_pred_npc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mis_cnt(mis_cnt));

  branch_predict_unit #(.IDX_W(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(s_f_pred_taken), .f_pred_npc(s_f_pred_npc),
    .r_valid(r_valid), .r_pc(r_pc), .r_cb(r_cb), .r_instr_index(r_instr_index), .r_offset(r_offset),
    .r_rs(r_rs), .r_rt(r_rt), .r_pred_taken(r_pred_taken), .r_pred_npc(r_pred_npc),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .br_cnt(s_br_cnt), .mis_cnt(s_mis_cnt));

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_npc);
    f_pc = pc;
    #1;
    tests++;
    if (f_pred_taken !== exp_tk) begin
      fails++; $display("FAIL %s pred_taken: got %0b expected %0b", name, f_pred_taken, exp_tk);
    end
    tests++;
    if (f_pred_npc !== exp_npc) begin
      fails++; $display("FAIL %s pred_npc: got %h expected %h", name, f_pred_npc, exp_npc);
    end
  endtask

  // Drive one resolve for a cycle; acc = bench expects it accepted, exp_v = expected mispredict pulse.
  task automatic resolve(input string name, input logic [3:0] cb, input logic [31:0] pc,
                         input logic [25:0] idx, input logic [15:0] off, input logic [31:0] rs,
                         input logic [31:0] rt, input logic ptk, input logic [31:0] pnpc,
                         input logic acc, input logic exp_v, input logic [31:0] npc);
    exp_t e;
    r_valid = 1'b1; r_cb = cb; r_pc = pc; r_instr_index = idx; r_offset = off;
    r_rs = rs; r_rt = rt; r_pred_taken = ptk; r_pred_npc = pnpc;
    if (exp_v) last_rpc = npc;
    sb_q.push_back('{v: exp_v, pc: last_rpc});
    if (acc && cb >= 4'd1 && cb <= 4'd7) exp_br++;
    if (exp_v) exp_mis++;
    @(posedge clk); #1;
    r_valid = 1'b0;
    e = sb_q.pop_front();
    tests++;
    if (redirect_valid !== e.v) begin
      fails++; $display("FAIL %s redirect_valid: got %0b expected %0b", name, redirect_valid, e.v);
    end
    tests++;
    if (redirect_pc !== e.pc) begin
      fails++; $display("FAIL %s redirect_pc: got %h expected %h", name, redirect_pc, e.pc);
    end
    tests++;
    if (br_cnt !== exp_br[15:0] || mis_cnt !== exp_mis[15:0]) begin
      fails++; $display("FAIL %s counters: got br=%0d mis=%0d expected br=%0d mis=%0d", name, br_cnt, mis_cnt, exp_br, exp_mis);
    end
    tests++;
    if (s_br_cnt !== 2'(sat3(exp_br)) || s_mis_cnt !== 2'(sat3(exp_mis))) begin
      fails++; $display("FAIL %s small_counters: got br=%0d mis=%0d expected br=%0d mis=%0d", name, s_br_cnt, s_mis_cnt, sat3(exp_br), sat3(exp_mis));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lookup("reset_lookup", 32'h0040_0000, 1'b0, 32'h0040_0004);
    tests++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || br_cnt !== 16'd0 || mis_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_outputs: got rv=%0b rpc=%h br=%0d mis=%0d expected all zero", redirect_valid, redirect_pc, br_cnt, mis_cnt);
    end
  endtask

  task automatic test_beq_alloc();
    resolve("beq_alloc", 4'd2, 32'h0040_0010, 26'd0, 16'h0003, 32'd5, 32'd5, 1'b0, 32'h0040_0014, 1'b1, 1'b1, 32'h0040_0020);
    idle();
    lookup("beq_alloc_lookup", 32'h0040_0010, 1'b1, 32'h0040_0020);
  endtask

  task automatic test_train();
    resolve("nt1", 4'd2, 32'h0040_0010, 26'd0, 16'h0003, 32'd1, 32'd2, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0014);
    idle();
    lookup("ctr1_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
    resolve("nt2", 4'd2, 32'h0040_0010, 26'd0, 16'h0003, 32'd1, 32'd2, 1'b0, 32'h0040_0014, 1'b1, 1'b0, 32'h0040_0014);
    lookup("ctr0_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
    for (int i = 0; i < 4; i++) begin
      resolve("tk", 4'd2, 32'h0040_0010, 26'd0, 16'h0003, 32'd5, 32'd5, 1'b0, 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0020);
    end
    lookup("ctr3_lookup", 32'h0040_0010, 1'b1, 32'h0040_0020);
    resolve("nt_after_sat", 4'd2, 32'h0040_0010, 26'd0, 16'h0003, 32'd1, 32'd2, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0014);
    idle();
    lookup("sat_lookup", 32'h0040_0010, 1'b1, 32'h0040_0020);
  endtask

  task automatic test_signed_and_jump();
    resolve("blez_neg", 4'd4, 32'h0040_0040, 26'd0, 16'h0010, 32'h8000_0000, 32'd0, 1'b0, 32'h0040_0044, 1'b1, 1'b1, 32'h0040_0084);
    idle();
    resolve("bgtz_neg", 4'd5, 32'h0040_0050, 26'd0, 16'h0010, 32'h8000_0000, 32'd0, 1'b0, 32'h0040_0054, 1'b1, 1'b0, 32'h0040_0054);
    resolve("jump", 4'd1, 32'h1000_0000, 26'h010_0000, 16'h0000, 32'd0, 32'd0, 1'b0, 32'h1000_0004, 1'b1, 1'b1, 32'h1040_0000);
    idle();
    lookup("jump_lookup", 32'h1000_0000, 1'b1, 32'h1040_0000);
  endtask

  task automatic test_back_to_back();
    resolve("b2b_first", 4'd3, 32'h0040_0084, 26'd0, 16'h0004, 32'd1, 32'd2, 1'b0, 32'h0040_0088, 1'b1, 1'b1, 32'h0040_0098);
    resolve("b2b_second", 4'd2, 32'h0040_0090, 26'd0, 16'h0002, 32'd7, 32'd7, 1'b0, 32'h0040_0094, 1'b0, 1'b0, 32'h0040_009C);
    lookup("b2b_no_train", 32'h0040_0090, 1'b0, 32'h0040_0094);
  endtask

  task automatic test_alias();
    idle();
    lookup("alias_before", 32'h0040_0010, 1'b1, 32'h0040_0020);
    resolve("alias_none", 4'd0, 32'h0040_0010, 26'd0, 16'h0003, 32'd5, 32'd5, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0014);
    idle();
    lookup("alias_after", 32'h0040_0010, 1'b0, 32'h0040_0014);
  endtask

  task automatic test_sat();
    tests++;
    if (s_br_cnt !== 2'd3 || s_mis_cnt !== 2'd3) begin
      fails++; $display("FAIL sat_hold: got br=%0d mis=%0d expected 3 3", s_br_cnt, s_mis_cnt);
    end
    resolve("sat_extra", 4'd1, 32'h1000_0000, 26'h010_0000, 16'h0000, 32'd0, 32'd0, 1'b1, 32'h1040_0000, 1'b1, 1'b0, 32'h1040_0000);
  endtask

  task automatic test_reset_mid();
    resolve("pre_reset", 4'd2, 32'h0040_0010, 26'd0, 16'h0003, 32'd5, 32'd5, 1'b0, 32'h0040_0014, 1'b1, 1'b1, 32'h0040_0020);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || br_cnt !== 16'd0 || s_br_cnt !== 2'd0) begin
      fails++; $display("FAIL mid_reset: got rv=%0b rpc=%h br=%0d sbr=%0d expected all zero", redirect_valid, redirect_pc, br_cnt, s_br_cnt);
    end
    exp_br = 0; exp_mis = 0; last_rpc = 32'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    lookup("post_reset_miss", 32'h0040_0010, 1'b0, 32'h0040_0014);
    lookup("post_reset_miss_j", 32'h1000_0000, 1'b0, 32'h1000_0004);
  endtask

  initial begin
    test_reset();
    test_beq_alloc();
    test_train();
    test_signed_and_jump();
    test_back_to_back();
    test_alias();
    test_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch/next-PC unit of the pipelined MIPS core.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
  - The IF stage gets a same-cycle predicted next PC.
  - The EX stage resolves the actual outcome (j, beq, bne, blez, bgtz, bltz, bgez), trains the table and issues a registered redirect on mispredict.
- Also keeps saturating branch and mispredict performance counters.

Parameters:
- IDX_W, 4, BTB index width; ENTRIES = 2**IDX_W.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_pc  in  32  IF-stage PC being fetched.
- f_pred_taken  out  1  BTB hit with counter bit[1] = 1.
- f_pred_npc  out  32  predicted next PC: stored target if f_pred_taken, else f_pc+4.
- r_valid  in  1  EX-stage resolve request valid.
- r_pc  in  32  PC of the resolving instruction.
- r_cb  in  4  branch class: 0 none, 1 j, 2 beq, 3 bne, 4 blez, 5 bgtz, 6 bltz, 7 bgez; 8..15 treated as none.
- r_instr_index  in  26  jump index field.
- r_offset  in  16  branch offset field.
- r_rs  in  32  rs operand.
- r_rt  in  32  rt operand.
- r_pred_taken  in  1  prediction carried down the pipe for this instruction.
- r_pred_npc  in  32  predicted next PC carried down the pipe.
- redirect_valid  out  1  one-cycle mispredict pulse.
- redirect_pc  out  32  correct next PC when redirect_valid = 1.
- br_cnt  out  CNT_W  resolved branches/jumps (r_cb 1..7).
- mis_cnt  out  CNT_W  mispredicts.

Behaviour:

Reset:
- All BTB valid bits clear; counters and targets zero.
- redirect_valid = 0, redirect_pc = 0, br_cnt = 0, mis_cnt = 0.
- Reset asserted mid-operation aborts any pending redirect immediately (asynchronous clear).

BTB entry fields and lookup:
- Entry fields: valid; tag = pc[31:IDX_W+2]; target[31:0]; ctr[1:0].
- Index = pc[IDX_W+1:2].
- Lookup is combinational from f_pc with zero latency.
- hit = valid && tag match.

Resolve (combinational, on r_pc):
- seq = r_pc + 4.
- btarget = seq + ({{14{r_offset[15]}}, r_offset, 2'b00}), modulo 2^32.
- jtarget = {r_pc[31:28], r_instr_index, 2'b00}.
- Taken conditions; comparisons are signed two's complement:
  - j: always taken.
  - beq: rs == rt.
  - bne: rs != rt.
  - blez: rs <= 0.
  - bgtz: rs > 0.
  - bltz: rs < 0.
  - bgez: rs >= 0.
  - none: never taken.
- actual_npc = taken ? (j ? jtarget : btarget) : seq.
- mispredict = (r_pred_npc != actual_npc).
- Only the PC compare decides mispredict; r_pred_taken is used for training only.

Accept rule:
- accept = r_valid && !redirect_valid.
- A resolve presented while redirect_valid = 1 is wrong-path and ignored: no training, no counter update, no redirect.

Outputs, one cycle after accept (registered):
- redirect_valid = accept && mispredict; redirect_pc = actual_npc.
- redirect_valid deasserts after one cycle.
- redirect_pc holds its last value when redirect_valid = 0.

Training, at the edge ending an accepted cycle:
- Hit, class 2..7:
  - ctr increments if taken, decrements if not; saturates at 3 and 0.
  - target is overwritten with btarget if taken.
- Hit, j: ctr = 3; target = jtarget.
- Hit, class none: entry is invalidated (aliased or stale entry).
- Miss and taken: allocate the entry (overwrite). Set valid = 1, tag, target, and ctr = 2 for conditionals or 3 for j.
- Miss and not taken: no change.

Same-cycle interactions:
- Fetch lookup and training to the same index in the same cycle: lookup returns the pre-update entry (no bypass).
- br_cnt increments on accept with r_cb in 1..7.
- mis_cnt increments on accept && mispredict, including class none.
- Both counters saturate at all-ones; they never wrap.

Test Plan:
- Reset, then f_pc = 0x00400000 -> f_pred_taken = 0, f_pred_npc = 0x00400004; all outputs 0.
- Resolve beq at r_pc = 0x00400010, offset 0x0003, rs = rt = 5, r_pred_npc = 0x00400014 -> next cycle redirect_valid = 1, redirect_pc = 0x00400020; br_cnt = 1, mis_cnt = 1. Then lookup of f_pc = 0x00400010 -> pred taken, npc 0x00400020.
- Same beq resolved not-taken twice (rs = 1, rt = 2): ctr 2 -> 1 -> 0, and lookup predicts not-taken after the first. Taken four times -> ctr saturates at 3.
- blez with rs = 0x80000000 -> taken (signed). bgtz with the same rs -> not taken. j with index 0x0100000 at r_pc = 0x10000000 -> npc 0x10400000.
- Redirect back-to-back: mispredicted resolve in cycle t; a second mispredicted resolve in t+1 is ignored (redirect_valid = 0 at t+2, counters unchanged). Alias: class none at a PC that hits -> entry invalidated, mis_cnt increments.
- Force br_cnt to all-ones via CNT_W = 2 -> holds at 3. Pulse rst_n low while redirect_valid = 1 -> redirect_valid drops immediately, BTB misses afterwards.
